uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one shared UART transmitter
// A transfer that never completes is aborted after TIMEOUT-1 cycles so the other requesters keep moving.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE, DRAIN} state_t;

  localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  last;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        found;

  assign cnt_next = cnt + 16'd1;

  // Search starts just after the last served index, so it is checked last.
  always_comb begin
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + 2'(k);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last        <= 2'd3;
      cnt         <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state           <= GRANT;
            grant_id        <= pick;
            tx_data         <= req_data[{pick, 3'b000} +: 8];
            req_ready[pick] <= 1'b1;
            tx_start        <= 1'b1;
            busy            <= 1'b1;
            cnt             <= '0;
          end
        end
        GRANT: begin
          cnt <= cnt_next;
          if (cnt_next == TERM) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            last        <= grant_id;
            state       <= DRAIN;
          end else if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt_next;
          // A completion on the terminal-count edge is still a normal completion.
          if (tx_done) begin
            last  <= grant_id;
            state <= DRAIN;
          end else if (cnt_next == TERM) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            last        <= grant_id;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;
  int last_m = 3;
  int grant_cyc = -100;

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return 8'(d >> (8 * i));
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'(1 << i);
  endfunction

  // Plays the transmitter from the grant cycle until the arbiter is idle again.
  task automatic run_xfer(input int bd, input int dd, input int dl,
                          output bit done_ok, output bit quiet, output bit start_ok);
    done_ok = 0; quiet = 1; start_ok = 1;
    for (int i = 0; i < bd; i++) begin
      if (tx_start !== 1'b1) start_ok = 0;
      @(negedge clk);
      if (req_ready !== 4'b0 || timeout_err !== 1'b0) quiet = 0;
    end
    if (tx_start !== 1'b1) start_ok = 0;
    tx_busy = 1'b1;
    @(negedge clk);
    if (req_ready !== 4'b0 || timeout_err !== 1'b0) quiet = 0;
    if (tx_start !== 1'b0) start_ok = 0;
    for (int i = 0; i < dd; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0 || timeout_err !== 1'b0 || busy !== 1'b1) quiet = 0;
    end
    tx_done = 1'b1;
    for (int i = 0; i < dl; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0 || timeout_err !== 1'b0 || busy !== 1'b1) quiet = 0;
    end
    tx_done = 1'b0;
    tx_busy = 1'b0;
    for (int i = 0; i < 20 && !done_ok; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0 || timeout_err !== 1'b0) quiet = 0;
      if (busy === 1'b0) done_ok = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passed++;
    rst = 1'b1;
    last_m = 3;
  endtask

  task automatic test_round_robin;
    int exp_order[5];
    bit d_ok, q_ok, s_ok;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = 4'hF;
    req_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (grant_id !== 2'(exp_order[i])) $display("FAIL rr_grant_%0d: got %0d want %0d", i, grant_id, exp_order[i]); else passed++;
      total++; if (req_ready !== onehot(exp_order[i])) $display("FAIL rr_ready_%0d: got %b want %b", i, req_ready, onehot(exp_order[i])); else passed++;
      total++; if (tx_data !== byte_of(req_data, exp_order[i])) $display("FAIL rr_data_%0d: got %h want %h", i, tx_data, byte_of(req_data, exp_order[i])); else passed++;
      if (i > 0) begin
        total++; if (cyc - grant_cyc != 4) $display("FAIL rr_spacing_%0d: got %0d want 4", i, cyc - grant_cyc); else passed++;
      end
      grant_cyc = cyc;
      last_m = exp_order[i];
      run_xfer(0, 0, 1, d_ok, q_ok, s_ok);
      total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL rr_xfer_%0d: got done=%b quiet=%b start=%b want 1 1 1", i, d_ok, q_ok, s_ok); else passed++;
    end
    req_valid = 4'h0;
  endtask

  task automatic test_single;
    bit bad;
    req_valid = 4'b0100;
    req_data = {$urandom} & 32'hFF00FFFF | 32'h00A50000;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else passed++;
    total++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else passed++;
    total++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else passed++;
    last_m = 2;
    req_valid = 4'b0000;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (tx_start !== 1'b1) bad = 1;
      @(negedge clk);
      if (req_ready !== 4'b0) bad = 1;
    end
    total++; if (bad || tx_start !== 1'b1) $display("FAIL single_start_held: got tx_start=%b bad=%b want held 1", tx_start, bad); else passed++;
    tx_busy = 1'b1;
    @(negedge clk);
    total++; if (tx_start !== 1'b0) $display("FAIL single_start_drop: got %b want 0", tx_start); else passed++;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_stretched_done;
    int w, w2;
    bit bad, d_ok, q_ok, s_ok;
    req_valid = 4'hF;
    req_data = $urandom;
    w = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (grant_id !== 2'(w)) $display("FAIL stretch_grant: got %0d want %0d", grant_id, w); else passed++;
    last_m = w;
    tx_busy = 1'b1;
    @(negedge clk);
    tx_done = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b1 || req_ready !== 4'b0 || timeout_err !== 1'b0) bad = 1;
    end
    total++; if (bad) $display("FAIL stretch_hold: got activity during held done want busy only"); else passed++;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL stretch_release: got busy=%b want 0", busy); else passed++;
    w2 = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (req_ready !== onehot(w2)) $display("FAIL stretch_next: got %b want %b", req_ready, onehot(w2)); else passed++;
    last_m = w2;
    run_xfer(1, 1, 1, d_ok, q_ok, s_ok);
    total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL stretch_xfer: got %b%b%b want 111", d_ok, q_ok, s_ok); else passed++;
    req_valid = 4'h0;
  endtask

  task automatic test_timeout;
    int w, w2;
    bit bad, d_ok, q_ok, s_ok;
    req_valid = 4'hF;
    req_data = $urandom;
    w = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (grant_id !== 2'(w)) $display("FAIL to_grant: got %0d want %0d", grant_id, w); else passed++;
    bad = 0;
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0 || tx_start !== 1'b1) bad = 1;
    end
    total++; if (bad) $display("FAIL to_early: got early timeout or tx_start drop want none before cycle 15"); else passed++;
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) $display("FAIL to_pulse: got %b want 1 at cycle 15", timeout_err); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL to_start: got %b want 0", tx_start); else passed++;
    last_m = w;
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", timeout_err); else passed++;
    w2 = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (grant_id !== 2'(w2) || req_ready !== onehot(w2)) $display("FAIL to_next: got id=%0d rdy=%b want id=%0d", grant_id, req_ready, w2); else passed++;
    last_m = w2;
    run_xfer(0, 2, 1, d_ok, q_ok, s_ok);
    total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL to_xfer: got %b%b%b want 111", d_ok, q_ok, s_ok); else passed++;
    req_valid = 4'h0;
  endtask

  task automatic test_collision;
    int w, w2;
    bit bad, d_ok, q_ok, s_ok;
    req_valid = 4'hF;
    req_data = $urandom;
    w = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (grant_id !== 2'(w)) $display("FAIL col_grant: got %0d want %0d", grant_id, w); else passed++;
    last_m = w;
    tx_busy = 1'b1;
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) bad = 1;
    end
    tx_done = 1'b1;
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) $display("FAIL col_no_timeout: got %b want 0", timeout_err); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL col_busy: got %b want 1", busy); else passed++;
    repeat (2) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) bad = 1;
    end
    total++; if (bad) $display("FAIL col_quiet: got timeout_err pulse want none"); else passed++;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL col_idle: got busy=%b terr=%b want 0 0", busy, timeout_err); else passed++;
    w2 = rr_pick(req_valid, last_m);
    @(negedge clk);
    total++; if (grant_id !== 2'(w2)) $display("FAIL col_next: got %0d want %0d", grant_id, w2); else passed++;
    last_m = w2;
    run_xfer(0, 0, 2, d_ok, q_ok, s_ok);
    total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL col_xfer: got %b%b%b want 111", d_ok, q_ok, s_ok); else passed++;
    req_valid = 4'h0;
  endtask

  task automatic test_random;
    logic [3:0]  vec;
    logic [31:0] dat;
    int w;
    bit d_ok, q_ok, s_ok;
    vec = 4'($urandom_range(0, 15));
    dat = $urandom;
    req_valid = vec;
    req_data = dat;
    for (int it = 0; it < 40; it++) begin
      if (vec == 4'b0) begin
        @(negedge clk);
        total++; if (req_ready !== 4'b0 || busy !== 1'b0) $display("FAIL rand_%0d_idle: got rdy=%b busy=%b want 0000 0", it, req_ready, busy); else passed++;
      end else begin
        w = rr_pick(vec, last_m);
        @(negedge clk);
        total++;
        if (req_ready !== onehot(w) || grant_id !== 2'(w) || tx_data !== byte_of(dat, w) || busy !== 1'b1)
          $display("FAIL rand_%0d_grant: got rdy=%b id=%0d data=%h want rdy=%b id=%0d data=%h", it, req_ready, grant_id, tx_data, onehot(w), w, byte_of(dat, w));
        else passed++;
        total++; if (cyc - grant_cyc < 4) $display("FAIL rand_%0d_spacing: got %0d want >=4", it, cyc - grant_cyc); else passed++;
        grant_cyc = cyc;
        last_m = w;
        vec = 4'($urandom_range(0, 15));
        dat = $urandom;
        req_valid = vec;
        req_data = dat;
        run_xfer($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(1, 5), d_ok, q_ok, s_ok);
        total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL rand_%0d_xfer: got %b%b%b want 111", it, d_ok, q_ok, s_ok); else passed++;
        continue;
      end
      vec = 4'($urandom_range(0, 15));
      dat = $urandom;
      req_valid = vec;
      req_data = dat;
    end
    req_valid = 4'h0;
    @(negedge clk);
    if (busy === 1'b1) begin
      tx_busy = 1'b1; tx_done = 1'b1;
      repeat (3) @(negedge clk);
      tx_busy = 1'b0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      last_m = grant_id;
    end
  endtask

  task automatic test_async_reset;
    bit d_ok, q_ok, s_ok;
    req_valid = 4'b0100;
    req_data = $urandom;
    @(negedge clk);
    total++; if (grant_id !== 2'd2) $display("FAIL ar_grant: got %0d want 2", grant_id); else passed++;
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else passed++;
    total++; if (tx_start !== 1'b0 || req_ready !== 4'b0) $display("FAIL ar_outputs: got start=%b rdy=%b want 0 0000", tx_start, req_ready); else passed++;
    total++; if (grant_id !== 2'd0 || tx_data !== 8'h00 || timeout_err !== 1'b0) $display("FAIL ar_regs: got id=%0d data=%h terr=%b want 0 00 0", grant_id, tx_data, timeout_err); else passed++;
    tx_busy = 1'b0;
    req_valid = 4'b0011;
    req_data = $urandom;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 4'b0 || busy !== 1'b0) $display("FAIL ar_held: got rdy=%b busy=%b want 0000 0", req_ready, busy); else passed++;
    rst = 1'b1;
    last_m = 3;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) $display("FAIL ar_first: got rdy=%b id=%0d want 0001 0", req_ready, grant_id); else passed++;
    total++; if (tx_data !== byte_of(req_data, 0)) $display("FAIL ar_data: got %h want %h", tx_data, byte_of(req_data, 0)); else passed++;
    last_m = 0;
    req_valid = 4'b0000;
    run_xfer(0, 1, 1, d_ok, q_ok, s_ok);
    total++; if (!(d_ok && q_ok && s_ok)) $display("FAIL ar_xfer: got %b%b%b want 111", d_ok, q_ok, s_ok); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stretched_done();
    test_timeout();
    test_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
